// File: rtl/rover_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rover_bus_arbiter_if
// Description : Bundles the requester-side and slave-side signals of the
//               rover register-bus arbiter. The master modport is the
//               arbiter's view; the slave modport is the environment's view
//               (requesters plus the shared register slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rover_bus_arbiter_if #(
    parameter int NUM_REQ = 4
) ();

    // Requester side
    logic [NUM_REQ-1:0]      req_i;
    logic [NUM_REQ-1:0]      req_we_i;
    logic [NUM_REQ*8-1:0]    req_addr_i;
    logic [NUM_REQ*32-1:0]   req_wdata_i;
    logic [NUM_REQ-1:0]      gnt_o;
    logic [NUM_REQ-1:0]      done_o;
    logic                    err_o;
    logic [31:0]             rdata_o;

    // Shared slave side
    logic                    s_valid_o;
    logic                    s_we_o;
    logic [7:0]              s_addr_o;
    logic [31:0]             s_wdata_o;
    logic                    s_ready_i;
    logic                    s_ack_i;
    logic [31:0]             s_rdata_i;

    modport master (
        input  req_i, req_we_i, req_addr_i, req_wdata_i,
        input  s_ready_i, s_ack_i, s_rdata_i,
        output gnt_o, done_o, err_o, rdata_o,
        output s_valid_o, s_we_o, s_addr_o, s_wdata_o
    );

    modport slave (
        output req_i, req_we_i, req_addr_i, req_wdata_i,
        output s_ready_i, s_ack_i, s_rdata_i,
        input  gnt_o, done_o, err_o, rdata_o,
        input  s_valid_o, s_we_o, s_addr_o, s_wdata_o
    );

endinterface
`default_nettype wire

// File: rtl/rover_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rover_bus_arbiter
// Description : Round-robin arbiter granting NUM_REQ requesters access to a
//               single register slave. Four-state FSM IDLE/ISSUE/WAIT/DONE.
//               Optional slave-response watchdog enabled by defining the
//               macro ARB_TIMEOUT_EN (default build: no watchdog, err_o = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module rover_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire                  clk,
    input  wire                  rst_n,
    rover_bus_arbiter_if.master  bus
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_SUM_W = c_IDX_W + 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam logic [c_IDX_W-1:0] c_LAST_RST     = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_SUM_W-1:0] c_NUM          = c_SUM_W'(NUM_REQ);
    localparam logic [c_SUM_W-1:0] c_ONE          = c_SUM_W'(1);
    localparam logic [31:0]        c_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Elaboration-time range checks on the configuration
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("rover_bus_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rover_bus_arbiter: TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [c_IDX_W-1:0]     r_winner;
    logic [c_IDX_W-1:0]     r_last_winner;
    logic [c_IDX_W-1:0]     w_winner;
    logic                   r_we;
    logic [7:0]             r_addr;
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic                   r_err;

    logic                   w_any_req;
    logic [2*NUM_REQ-1:0]   w_req_shift;
    logic [NUM_REQ-1:0]     w_req_rot;
    logic [c_SUM_W-1:0]     w_offset;
    logic [c_SUM_W-1:0]     w_sum;
    logic                   w_sel_we;
    logic [7:0]             w_sel_addr;
    logic [31:0]            w_sel_wdata;
    logic                   w_timeout;
    logic                   w_ack_done;

    // Round-robin pick: rotate requests so last_winner+1 sits at bit 0,
    // take the lowest set bit, then rotate the index back.
    always_comb begin
        w_any_req   = |bus.req_i;
        w_req_shift = {bus.req_i, bus.req_i} >> ({1'b0, r_last_winner} + c_ONE);
        w_req_rot   = w_req_shift[NUM_REQ-1:0];
        w_offset    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_offset = c_SUM_W'(i);
            end
        end
        w_sum = {1'b0, r_last_winner} + c_ONE + w_offset;
        if (w_sum >= c_NUM) begin
            w_sum = w_sum - c_NUM;
        end
        w_winner = w_sum[c_IDX_W-1:0];

        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == c_IDX_W'(i)) begin
                w_sel_we    = bus.req_we_i[i];
                w_sel_addr  = bus.req_addr_i[8*i +: 8];
                w_sel_wdata = bus.req_wdata_i[32*i +: 32];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] c_TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_timeout_cnt;

    // Watchdog: held at zero in IDLE so it starts from 0 on ISSUE entry,
    // counts every ISSUE/WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_cnt <= '0;
        end else if (r_state == c_S_IDLE) begin
            r_timeout_cnt <= '0;
        end else if (r_state == c_S_ISSUE || r_state == c_S_WAIT) begin
            r_timeout_cnt <= r_timeout_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state == c_S_ISSUE || r_state == c_S_WAIT) &&
                       (r_timeout_cnt == c_TIMEOUT_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    // An acknowledge in WAIT beats a coincident timeout
    assign w_ack_done = (r_state == c_S_WAIT) && bus.s_ack_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = c_S_ISSUE;
                end
            end
            c_S_ISSUE: begin
                if (w_timeout) begin
                    w_next_state = c_S_DONE;
                end else if (bus.s_ready_i) begin
                    w_next_state = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (bus.s_ack_i || w_timeout) begin
                    w_next_state = c_S_DONE;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // Command latch and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner      <= '0;
            r_last_winner <= c_LAST_RST;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else begin
            if (r_state == c_S_IDLE && w_any_req) begin
                r_winner <= w_winner;
                r_we     <= w_sel_we;
                r_addr   <= w_sel_addr;
                r_wdata  <= w_sel_wdata;
            end
            if (r_state == c_S_DONE) begin
                r_last_winner <= r_winner;
            end
        end
    end

    // Completion status: read data capture and timeout flag for DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_timeout && !w_ack_done) begin
                r_err   <= 1'b1;
                r_rdata <= c_TIMEOUT_DATA;
            end else if (w_ack_done && !r_we) begin
                r_rdata <= bus.s_rdata_i;
            end
        end
    end

    // Outputs decoded from state and latched command
    always_comb begin
        bus.gnt_o  = '0;
        bus.done_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_winner == c_IDX_W'(i)) begin
                bus.gnt_o[i]  = (r_state != c_S_IDLE);
                bus.done_o[i] = (r_state == c_S_DONE);
            end
        end
        bus.err_o     = (r_state == c_S_DONE) && r_err;
        bus.rdata_o   = r_rdata;
        bus.s_valid_o = (r_state == c_S_ISSUE);
        bus.s_we_o    = r_we;
        bus.s_addr_o  = r_addr;
        bus.s_wdata_o = r_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_rover_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rover_bus_arbiter
// Description : Self-checking bench for rover_bus_arbiter. Stimulus pushes the
//               expected completion (cycle, done/grant vector, err, rdata)
//               into a queue; a monitor pops and compares on each done_o.
//               Timeout scenarios run only when ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rover_bus_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rover_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    rover_bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [3:0]  done;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mem [256];

    // Slave model controls
    int   slv_ready_delay = 0;
    int   slv_ack_delay   = 0;
    bit   slv_no_ack      = 1'b0;
    bit   in_wait         = 1'b0;
    int   rdy_cnt         = 0;
    int   ack_cnt         = 0;
    logic [31:0] slv_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_done(int c, logic [3:0] d, logic e, logic [31:0] r);
        exp_t x;
        x.cyc = c; x.done = d; x.err = e; x.rdata = r;
        sb.push_back(x);
    endtask

    task automatic set_req(int k, logic we, logic [7:0] a, logic [31:0] d);
        bus.req_we_i[k]          = we;
        bus.req_addr_i[8*k +: 8] = a;
        bus.req_wdata_i[32*k +: 32] = d;
    endtask

    // Slave: ready after slv_ready_delay ISSUE cycles, ack after slv_ack_delay WAIT cycles
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.s_ready_i = 1'b0;
            bus.s_ack_i   = 1'b0;
            bus.s_rdata_i = '0;
            in_wait = 1'b0;
            rdy_cnt = 0;
            ack_cnt = 0;
        end else begin
            bus.s_ack_i = 1'b0;
            if (|bus.done_o) in_wait = 1'b0;
            if (in_wait) begin
                if (!slv_no_ack && ack_cnt == slv_ack_delay) begin
                    bus.s_ack_i   = 1'b1;
                    bus.s_rdata_i = slv_data;
                    in_wait = 1'b0;
                end else begin
                    ack_cnt++;
                end
            end
            if (bus.s_valid_o) begin
                if (rdy_cnt == slv_ready_delay) begin
                    bus.s_ready_i = 1'b1;
                    slv_data = mem[bus.s_addr_o];
                    in_wait  = 1'b1;
                    ack_cnt  = 0;
                end else begin
                    bus.s_ready_i = 1'b0;
                    rdy_cnt++;
                end
            end else begin
                bus.s_ready_i = 1'b0;
                rdy_cnt = 0;
            end
        end
    end

    // Monitor: every done_o pulse is matched against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done_o != '0) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: done_o=%b with nothing expected (cycle %0d)", bus.done_o, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_o",     32'(bus.done_o), 32'(mon_e.done));
                    check("gnt_o",      32'(bus.gnt_o),  32'(mon_e.done));
                    check("err_o",      32'(bus.err_o),  32'(mon_e.err));
                    check("rdata_o",    bus.rdata_o,     mon_e.rdata);
                    check("done_cycle", 32'(cyc),        32'(mon_e.cyc));
                end
            end else if (bus.err_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL err_without_done: err_o=1 done_o=0 (cycle %0d)", cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hABCD_EF10;
        mem[8'h11] = 32'hABCD_EF11;
        mem[8'h12] = 32'hABCD_EF12;
        mem[8'h13] = 32'hABCD_EF13;
        mem[8'h1C] = 32'h1234_5678;
        mem[8'h33] = 32'h3333_3333;
        mem[8'h77] = 32'h7777_7777;
        bus.req_i       = '0;
        bus.req_we_i    = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_gnt",     32'(bus.gnt_o),     32'h0);
        check("rst_done",    32'(bus.done_o),    32'h0);
        check("rst_err",     32'(bus.err_o),     32'h0);
        check("rst_s_valid", 32'(bus.s_valid_o), 32'h0);
        check("rst_s_we",    32'(bus.s_we_o),    32'h0);
        check("rst_s_addr",  32'(bus.s_addr_o),  32'h0);
        check("rst_s_wdata", bus.s_wdata_o,      32'h0);
        check("rst_rdata",   bus.rdata_o,        32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // All requesters held: grants 0,1,2,3,0 every 4 cycles; requester 2 writes
        set_req(0, 1'b0, 8'h10, 32'h0);
        set_req(1, 1'b0, 8'h11, 32'h0);
        set_req(2, 1'b1, 8'h12, 32'h2222_2222);
        set_req(3, 1'b0, 8'h13, 32'h0);
        bus.req_i = 4'hF;
        c = cyc;
        expect_done(c + 3,  4'b0001, 1'b0, 32'hABCD_EF10);
        expect_done(c + 7,  4'b0010, 1'b0, 32'hABCD_EF11);
        expect_done(c + 11, 4'b0100, 1'b0, 32'hABCD_EF11);
        expect_done(c + 15, 4'b1000, 1'b0, 32'hABCD_EF13);
        expect_done(c + 19, 4'b0001, 1'b0, 32'hABCD_EF10);
        repeat (17) @(negedge clk);
        bus.req_i = '0;
        repeat (4) @(negedge clk);

        // Single read from requester 1, immediate ready, ack next cycle
        set_req(1, 1'b0, 8'h1C, 32'h0);
        bus.req_i = 4'b0010;
        c = cyc;
        expect_done(c + 3, 4'b0010, 1'b0, 32'h1234_5678);
        @(negedge clk);
        check("rd_s_valid", 32'(bus.s_valid_o), 32'h1);
        check("rd_gnt",     32'(bus.gnt_o),     32'h2);
        check("rd_s_addr",  32'(bus.s_addr_o),  32'h1C);
        check("rd_s_we",    32'(bus.s_we_o),    32'h0);
        bus.req_i = '0;
        repeat (4) @(negedge clk);

        // Write with ready delayed 5 cycles; inputs change mid-transaction
        slv_ready_delay = 5;
        set_req(3, 1'b1, 8'h33, 32'hFEED_F00D);
        bus.req_i = 4'b1000;
        c = cyc;
        expect_done(c + 8, 4'b1000, 1'b0, 32'h1234_5678);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("wr_s_valid", 32'(bus.s_valid_o), 32'h1);
            check("wr_s_addr",  32'(bus.s_addr_o),  32'h33);
            check("wr_s_wdata", bus.s_wdata_o,      32'hFEED_F00D);
            if (k == 0) begin
                set_req(3, 1'b1, 8'h77, 32'h0);
                bus.req_i = '0;
            end
        end
        @(negedge clk);
        check("wr_valid_drop", 32'(bus.s_valid_o), 32'h0);
        slv_ready_delay = 0;
        repeat (3) @(negedge clk);

        // Requester 2 completes so last_winner = 2
        set_req(2, 1'b1, 8'h12, 32'h2222_2222);
        bus.req_i = 4'b0100;
        c = cyc;
        expect_done(c + 3, 4'b0100, 1'b0, 32'h1234_5678);
        @(negedge clk);
        bus.req_i = '0;
        repeat (4) @(negedge clk);

        // Requester 3 stalls in WAIT, then asynchronous reset aborts it
        slv_no_ack = 1'b1;
        bus.req_i = 4'b1000;
        @(negedge clk);
        bus.req_i = '0;
        repeat (3) @(negedge clk);
        check("pre_rst_gnt",     32'(bus.gnt_o),     32'h8);
        check("pre_rst_s_valid", 32'(bus.s_valid_o), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt",     32'(bus.gnt_o),     32'h0);
        check("arst_done",    32'(bus.done_o),    32'h0);
        check("arst_s_valid", 32'(bus.s_valid_o), 32'h0);
        check("arst_s_addr",  32'(bus.s_addr_o),  32'h0);
        check("arst_s_wdata", bus.s_wdata_o,      32'h0);
        check("arst_rdata",   bus.rdata_o,        32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slv_no_ack = 1'b0;
        @(negedge clk);

        // First grant after reset goes to the lowest active requester
        set_req(1, 1'b0, 8'h1C, 32'h0);
        bus.req_i = 4'b1010;
        c = cyc;
        expect_done(c + 3, 4'b0010, 1'b0, 32'h1234_5678);
        @(negedge clk);
        bus.req_i = '0;
        repeat (4) @(negedge clk);

`ifdef ARB_TIMEOUT_EN
        // No ack: timeout 16 cycles after ISSUE entry
        slv_no_ack = 1'b1;
        set_req(0, 1'b0, 8'h10, 32'h0);
        bus.req_i = 4'b0001;
        c = cyc;
        expect_done(c + 17, 4'b0001, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.req_i = '0;
        repeat (19) @(negedge clk);
        slv_no_ack = 1'b0;

        // Ack on the limit cycle wins over the timeout
        slv_ack_delay = 14;
        bus.req_i = 4'b0001;
        c = cyc;
        expect_done(c + 17, 4'b0001, 1'b0, 32'hABCD_EF10);
        @(negedge clk);
        bus.req_i = '0;
        repeat (19) @(negedge clk);
        slv_ack_delay = 0;
`endif

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rover_bus_arbiter.md
ROVER_BUS_ARBITER -- requirements
Module: rover_bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the register bus (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, slave-response watchdog limit in clk cycles (2..65535).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_i  in  NUM_REQ  per-requester transaction request, level.
REQ-006 req_we_i  in  NUM_REQ  per-requester write enable (1 write, 0 read).
REQ-007 req_addr_i  in  NUM_REQ*8  packed addresses, requester k at bits [8k+7:8k].
REQ-008 req_wdata_i  in  NUM_REQ*32  packed write data, requester k at bits [32k+31:32k].
REQ-009 gnt_o  out  NUM_REQ  one-hot grant, held from ISSUE through DONE.
REQ-010 done_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 err_o  out  1  one-cycle timeout pulse, coincident with done_o.
REQ-012 rdata_o  out  32  read data of last completed transaction, held until next completion.
REQ-013 s_valid_o / s_we_o / s_addr_o(8) / s_wdata_o(32)  out  shared slave command.
REQ-014 s_ready_i  in  1  slave accepts command; s_ack_i  in  1  slave completion; s_rdata_i  in  32  slave read data.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT, DONE; exactly one active.
REQ-016 IDLE: if any req_i bit set, select winner round-robin starting at last_winner+1 (mod NUM_REQ), latch its we/addr/wdata, go ISSUE; else stay.
REQ-017 ISSUE: s_valid_o=1 with latched command; on s_valid_o&&s_ready_i go WAIT next cycle.
REQ-018 WAIT: s_valid_o=0; on s_ack_i capture s_rdata_i into rdata_o (reads only; writes leave rdata_o unchanged), go DONE.
REQ-019 DONE: done_o[winner]=1 for one cycle, last_winner<=winner, go IDLE.
REQ-020 Latency: req_i seen in IDLE cycle N -> s_valid_o at N+1; ready at N+1 and ack at N+2 -> done_o at N+3.
REQ-021 req_i sampled only in IDLE; deassertion mid-transaction is ignored, transaction completes.
REQ-022 s_ack_i during ISSUE or IDLE is ignored; s_ready_i outside ISSUE is ignored.
REQ-023 Held request re-arbitrates in IDLE after DONE; with all requesters active, grants rotate 0,1,2,...,NUM_REQ-1,0.
REQ-024 Latched command stable for the whole transaction regardless of req_*_i changes.

Reset
REQ-025 rst_n low: state IDLE, gnt_o=0, done_o=0, err_o=0, s_valid_o=0, s_we_o=0, s_addr_o=0, s_wdata_o=0, rdata_o=0, last_winner=NUM_REQ-1, timeout counter 0.
REQ-026 Reset mid-transaction aborts immediately with no done_o pulse; first post-reset grant goes to lowest active index.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: 16-bit counter clears on entering ISSUE, increments each ISSUE/WAIT cycle; on reaching TIMEOUT_CYCLES-1 go DONE with err_o=1, rdata_o=32'hDEAD_BEEF.
REQ-028 Timeout and s_ack_i in the same cycle: ack wins, err_o=0, normal data captured.
REQ-029 Macro undefined: no counter, ISSUE/WAIT wait indefinitely, err_o tied 0.

Verification
REQ-030 Single read: req_i=4'b0010, addr 8'h1C, ready immediate, ack next cycle with 32'h1234_5678 -> gnt_o=4'b0010, done_o[1] pulse at N+3, rdata_o=32'h1234_5678.
REQ-031 All four req_i held, slave always ready/acks -> grant order 0,1,2,3,0 with no requester skipped.
REQ-032 Write with s_ready_i delayed 5 cycles -> s_valid_o held 6 cycles with constant addr/wdata, rdata_o unchanged.
REQ-033 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> err_o and done_o pulse 16 cycles after ISSUE entry, rdata_o=32'hDEAD_BEEF; ack on the limit cycle -> err_o=0.
REQ-034 rst_n pulsed low during WAIT -> all outputs zero asynchronously, no done_o, next grant to lowest active requester.
